// File: rtl/wb_stage.sv
// Writeback stage: latches the execute/memory result bus, writes the register file,
// forwards pending write data, and queues one retirement record per instruction for the trace sink.
// Optional retired-instruction counter enabled by defining WB_INSTRET_EN.
module wb_stage #(
    parameter int ES_TO_WS_BUS_WD = 70,
    parameter int TRACE_DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       es_to_ws_valid,
    input  logic [ES_TO_WS_BUS_WD-1:0] es_to_ws_bus,
    output logic                       ws_allowin,
    output logic                       rf_we,
    output logic [4:0]                 rf_waddr,
    output logic [31:0]                rf_wdata,
    output logic [36:0]                ws_forward_bus,
    output logic                       debug_valid,
    input  logic                       debug_ready,
    output logic [31:0]                debug_wb_pc,
    output logic [3:0]                 debug_wb_rf_we,
    output logic [4:0]                 debug_wb_rf_wnum,
    output logic [31:0]                debug_wb_rf_wdata,
    output logic [63:0]                instret
);

    localparam int PTR_W = $clog2(TRACE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  we;
        logic [4:0]  wnum;
        logic [31:0] wdata;
    } trace_t;

    logic                       ws_valid_q, ws_valid_d;
    logic [ES_TO_WS_BUS_WD-1:0] bus_q, bus_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]           count_q, count_d;
    trace_t                     fifo_mem_q [TRACE_DEPTH];

    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
    logic        writes_gpr;
    logic        fifo_full;
    logic        pop;
    logic        ws_ready_go;
    logic        retire;
    trace_t      push_entry;
    trace_t      head;

    assign gr_we        = bus_q[69];
    assign dest         = bus_q[68:64];
    assign final_result = bus_q[63:32];
    assign pc           = bus_q[31:0];
    assign writes_gpr   = gr_we && (dest != 5'd0);

    assign fifo_full   = (count_q == CNT_W'(TRACE_DEPTH));
    assign debug_valid = (count_q != '0);
    assign pop         = debug_valid && debug_ready;
    // A pop in the same cycle frees the slot the retiring instruction needs.
    assign ws_ready_go = !fifo_full || pop;
    assign ws_allowin  = !ws_valid_q || ws_ready_go;
    assign retire      = ws_valid_q && ws_ready_go;

    assign rf_we          = retire && writes_gpr;
    assign rf_waddr       = dest;
    assign rf_wdata       = final_result;
    assign ws_forward_bus = (ws_valid_q && writes_gpr) ? {final_result, dest} : 37'b0;

    assign push_entry = '{
        pc:    pc,
        we:    writes_gpr ? 4'hf : 4'h0,
        wnum:  writes_gpr ? dest : 5'd0,
        wdata: writes_gpr ? final_result : 32'd0
    };

    // Head data is gated so stale, never-reset storage cannot leak out when empty.
    assign head              = fifo_mem_q[rd_ptr_q];
    assign debug_wb_pc       = debug_valid ? head.pc    : 32'd0;
    assign debug_wb_rf_we    = debug_valid ? head.we    : 4'h0;
    assign debug_wb_rf_wnum  = debug_valid ? head.wnum  : 5'd0;
    assign debug_wb_rf_wdata = debug_valid ? head.wdata : 32'd0;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        ws_valid_d = ws_valid_q;
        bus_d      = bus_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q + CNT_W'(retire) - CNT_W'(pop);
        if (ws_allowin) begin
            ws_valid_d = es_to_ws_valid;
            if (es_to_ws_valid) begin
                bus_d = es_to_ws_bus;
            end
        end
        if (retire) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ws_valid_q <= 1'b0;
            bus_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            ws_valid_q <= ws_valid_d;
            bus_q      <= bus_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (retire) begin
            fifo_mem_q[wr_ptr_q] <= push_entry;
        end
    end

`ifdef WB_INSTRET_EN
    logic [63:0] instret_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instret_q <= 64'd0;
        end else if (retire) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    assign instret = instret_q;
`else
    assign instret = 64'b0;
`endif

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Final (writeback) pipeline stage, directly downstream of the execute/memory stage.
- Latches the 70-bit result bus, drives the register-file write port, and drives a writeback forwarding bus back to the execute stage.
- Pushes one retirement record per instruction into a small trace FIFO, drained by the difftest/trace sink over a valid/ready handshake.
- Backpressures the pipeline via ws_allowin when the trace FIFO is full.

Parameters:
- ES_TO_WS_BUS_WD, 70: width of incoming bus; layout {gr_we[69], dest[68:64], final_result[63:32], pc[31:0]}.
- TRACE_DEPTH, 4: trace FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- es_to_ws_valid  in  1  upstream has a valid instruction.
- es_to_ws_bus  in  ES_TO_WS_BUS_WD  upstream payload.
- ws_allowin  out  1  stage can accept a new instruction this cycle.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  5  register-file write address.
- rf_wdata  out  32  register-file write data.
- ws_forward_bus  out  37  {wdata[36:5], dest[4:0]}; all-zero when not writing.
- debug_valid  out  1  trace FIFO head valid.
- debug_ready  in  1  trace sink accepts head.
- debug_wb_pc  out  32  retired pc.
- debug_wb_rf_we  out  4  4'hf if the instruction wrote a GPR, else 4'h0.
- debug_wb_rf_wnum  out  5  written register number.
- debug_wb_rf_wdata  out  32  written data.
- instret  out  64  retired-instruction count (optional feature).

Behaviour:
- Reset (async, asserted): ws_valid=0; bus register=0; FIFO read/write pointers and count=0; instret=0.
- Resulting outputs under reset: ws_allowin=1, rf_we=0, ws_forward_bus=0, debug_valid=0, debug_* data=0.
- Stage handshake:
  - ws_ready_go = !fifo_full || (debug_valid && debug_ready).
  - ws_allowin = !ws_valid || ws_ready_go.
  - On a clock edge with ws_allowin=1: ws_valid <= es_to_ws_valid; the bus register loads only when es_to_ws_valid=1, otherwise holds.
- Retire event: retire = ws_valid && ws_ready_go. Exactly one retire per accepted instruction; a stalled instruction holds its state and does not retire twice.
- Register-file write:
  - rf_we = retire && gr_we && (dest != 0); rf_waddr = dest; rf_wdata = final_result.
  - Writes to r0 are suppressed.
- Forwarding: ws_forward_bus = {final_result, dest} when ws_valid && gr_we && dest != 0, else 37'b0. It is driven while stalled (data is committed-to-be).
- Trace FIFO push: on retire, push {pc, we?4'hf:4'h0, we?dest:0, we?final_result:0}, where we = gr_we && dest != 0.
- Trace FIFO pop: when debug_valid && debug_ready. Simultaneous push and pop on a full FIFO is legal; count is unchanged.
- Trace FIFO pointers: wrap modulo TRACE_DEPTH.
- debug_valid = (count != 0); the debug_* outputs present the head entry.
- Latency:
  - Bus accepted at edge N -> retire in cycle N..N+1.
  - rf write commits at edge N+1 if not stalled.
  - Trace record visible at debug outputs after edge N+1 (no FIFO bypass).
- Full FIFO with debug_ready=0: ws_ready_go=0 and ws_allowin=0 while ws_valid. Upstream must hold. No rf write and no push occur until space frees.
- Empty FIFO: debug_valid=0 and debug_ready is ignored; no underflow.
- Reset mid-stall: the in-flight instruction and all FIFO contents are discarded; no rf write in the reset cycle.

Optional Feature:
- WB_INSTRET_EN defined: 64-bit instret increments by 1 on every retire, wraps at 2^64-1 -> 0, and resets to 0.
- WB_INSTRET_EN undefined: no counter flops; instret tied to 64'b0.

Test Plan:
- Single write: push bus {gr_we=1, dest=5, res=32'h1234_5678, pc=32'h1c00_0000} with debug_ready=1.
  - Expect rf_we=1, waddr=5, wdata=32'h12345678 one cycle after acceptance.
  - Expect debug_valid=1 the next cycle with pc=32'h1c000000, rf_we=4'hf, wnum=5.
- r0 / no-write: gr_we=1, dest=0, then gr_we=0, dest=7.
  - Expect rf_we=0 and ws_forward_bus=0 for both.
  - Expect two trace entries with debug_wb_rf_we=4'h0, wnum=0, wdata=0.
- Backpressure: debug_ready=0, stream 6 valid instructions back-to-back.
  - After 4 retires the FIFO is full; ws_allowin drops to 0 with the 5th held in stage; rf_we=0 while held.
  - Raise debug_ready: traces drain in order with pcs 0x0, 0x4, ..., 0x14; exactly 6 rf writes total.
- Simultaneous push/pop at full: with FIFO full and debug_ready=1 with a valid instruction in stage, the instruction retires the same cycle as the pop and count stays 4.
- Async reset mid-stall: assert reset between clock edges while full and stalled.
  - Expect ws_allowin=1, debug_valid=0, rf_we=0 immediately.
  - Expect no further trace output after release until new input.
- WB_INSTRET_EN: retire 10 instructions including 2 stalled cycles -> instret=10. With the macro undefined, instret=0 throughout.
